dsp_mac_seq: RTL and testbench
==============================

Name: dsp_mac_seq

Overview:
Sequencer for one DSP48A1-style multiply/accumulate slice. It accepts a job of N operand pairs through a valid/ready handshake. It drives the slice's operand-register and P-register clock enables, plus OPMODE aligned to the pipeline latency, so that P = sum of A*B over the job. It sits between the sample source and the DSP slice datapath, and signals completion when P holds the final sum.

Parameters:
LEN_W, 8, width of job length and remaining-sample counter
PIPE_LAT, 4, cycles from operand-register capture to P register update edge inclusive; legal range 2..16

Ports:
clk  in  1  single clock, all logic on rising edge
rstn  in  1  synchronous active-low reset; sampled on rising edge of clk
start  in  1  job request, sampled only when ready for a job
len  in  LEN_W  number of operand pairs in job, sampled with accepted start
abort  in  1  cancel current job
smp_valid  in  1  operand pair available at slice A/B inputs
smp_ready  out  1  block will capture operand pair this cycle
ce_ab  out  1  clock enable for A/B operand registers
ce_mid  out  1  clock enable for intermediate stages (M and pre-adder)
ce_p  out  1  clock enable for P register
rst_p  out  1  active-high synchronous clear for P register
opmode  out  8  slice OPMODE for the sample currently reaching P
busy  out  1  job in progress
done  out  1  one-cycle pulse; P holds final sum this cycle
err  out  1  one-cycle pulse on start with len==0

Behaviour:
- States: IDLE, RUN, DRAIN, DONE. Reset (rstn=0 at edge) forces IDLE and clears counter and tag pipeline.
- Values while in reset and in IDLE: all outputs 0, with two exceptions:
  - rst_p=1 during the reset cycle, so P is cleared.
  - opmode=8'h00.
- Job acceptance: a start is accepted in IDLE or DONE.
  - On an accepted start with len!=0, the block loads cnt=len and moves to RUN next cycle.
  - On an accepted start with len==0, the block pulses err next cycle and stays in or returns to IDLE.
  - start in RUN/DRAIN is ignored.
- RUN: smp_ready=1 while cnt>0.
  - Accept = smp_valid & smp_ready. ce_ab=accept. cnt decrements on accept.
  - Each accept pushes a tag {vld, first, last} into a PIPE_LAT-1 deep shift line. first marks the first accept of the job; last is set when cnt==1.
  - Once the last tag is pushed, go to DRAIN next cycle. smp_ready=0 in DRAIN.
- ce_mid=1 in RUN and DRAIN.
- Tag output stage (delay PIPE_LAT-1 cycles after accept):
  - If vld: ce_p=1 and opmode=8'h01 when first (X=M, Z=0), or 8'h09 otherwise (X=M, Z=P).
  - If not vld: ce_p=0 and opmode=8'h00.
  - Bubbles (smp_valid low) therefore hold P unchanged.
- DRAIN to DONE: the block enters DONE on the cycle after the last tag reaches the output stage. So done rises exactly PIPE_LAT cycles after the last accept.
- DONE lasts 1 cycle: done=1, busy=0. The next state is IDLE, or RUN if start is accepted in the same cycle (back-to-back jobs; the new first tag zeroes Z, so no P clear is needed).
- busy=1 in RUN and DRAIN only.
- abort in RUN or DRAIN:
  - Next state is IDLE, the tag line is flushed, and rst_p=1 for one cycle.
  - No done pulse and no further ce_p.
  - abort in IDLE or DONE is ignored.
  - abort together with start in DONE: abort wins and start is dropped.
- Simultaneous events: reset dominates abort, and abort dominates smp_valid.
- cnt never wraps. A len of all-ones (2^LEN_W-1) is legal.

Test Plan:
- PIPE_LAT=4, start at cycle 0 with len=3, smp_valid held high -> accepts at cycles 1,2,3; ce_p at cycles 4,5,6 with opmode 01,09,09; done at cycle 7; busy high cycles 1-6.
- len=4 with smp_valid low on the 2nd and 3rd sample cycles -> ce_ab count 4; ce_p gaps mirror the bubbles; done exactly 4 cycles after the last accept; only the first ce_p has opmode 01.
- abort asserted in DRAIN one cycle before done is due -> rst_p pulses once, no done, no further ce_p, busy=0 next cycle, then a new start works normally.
- start with len=0 in IDLE -> err pulse next cycle, busy stays 0, no ce_ab/ce_p. Separately, start asserted during RUN -> ignored, and the job length is unchanged.
- start asserted in the DONE cycle with len=2 -> RUN next cycle with no idle gap; the second job's first ce_p uses opmode 01.
- rstn low for one cycle mid-RUN -> all outputs 0 except rst_p=1, state IDLE, pending tags dropped, no done.

Source files
------------

// File: rtl/dsp_mac_seq.sv
// Sequencer for a DSP48A1-style MAC slice: counts a job of operand pairs and
// issues operand/P clock enables and OPMODE, delayed to match the slice pipeline.
module dsp_mac_seq #(
   parameter int LEN_W    = 8,
   parameter int PIPE_LAT = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             abort,
   input  logic             smp_valid,
   output logic             smp_ready,
   output logic             ce_ab,
   output logic             ce_mid,
   output logic             ce_p,
   output logic             rst_p,
   output logic [7:0]       opmode,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int DEPTH = PIPE_LAT - 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t           state_reg;
   logic [LEN_W-1:0] cnt_reg;
   logic             first_reg;
   logic             err_reg;
   logic [DEPTH-1:0] vld_reg;
   logic [DEPTH-1:0] first_tag_reg;
   logic [DEPTH-1:0] last_tag_reg;

   logic in_job;
   logic abort_hit;
   logic accept;
   logic cnt_is_one;
   logic tag_out_vld;

   assign in_job     = (state_reg == RUN) || (state_reg == DRAIN);
   assign abort_hit  = rstn && abort && in_job;
   assign cnt_is_one = (cnt_reg == LEN_W'(1));
   // abort dominates a pending operand: nothing is captured in the abort cycle
   assign smp_ready  = rstn && (state_reg == RUN) && (cnt_reg != '0) && !abort;
   assign accept     = smp_ready && smp_valid;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         first_reg <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         err_reg <= 1'b0;
         case (state_reg)
            IDLE, DONE: begin
               state_reg <= IDLE;
               if (start && !(state_reg == DONE && abort)) begin
                  if (len != '0) begin
                     state_reg <= RUN;
                     cnt_reg   <= len;
                     first_reg <= 1'b1;
                  end else begin
                     err_reg <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (abort) begin
                  state_reg <= IDLE;
                  cnt_reg   <= '0;
               end else if (accept) begin
                  cnt_reg   <= cnt_reg - LEN_W'(1);
                  first_reg <= 1'b0;
                  if (cnt_is_one) state_reg <= DRAIN;
               end
            end
            DRAIN: begin
               if (abort) begin
                  state_reg <= IDLE;
               end else if (vld_reg[DEPTH-1] && last_tag_reg[DEPTH-1]) begin
                  state_reg <= DONE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Tag line: stage DEPTH-1 lines up with the P register update edge.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tag
         always_ff @(posedge clk) begin
            if (!rstn || abort_hit) begin
               vld_reg[gi]       <= 1'b0;
               first_tag_reg[gi] <= 1'b0;
               last_tag_reg[gi]  <= 1'b0;
            end else if (gi == 0) begin
               vld_reg[gi]       <= accept;
               first_tag_reg[gi] <= accept && first_reg;
               last_tag_reg[gi]  <= accept && cnt_is_one;
            end else begin
               vld_reg[gi]       <= vld_reg[(gi == 0) ? 0 : gi-1];
               first_tag_reg[gi] <= first_tag_reg[(gi == 0) ? 0 : gi-1];
               last_tag_reg[gi]  <= last_tag_reg[(gi == 0) ? 0 : gi-1];
            end
         end
      end
   endgenerate

   assign tag_out_vld = rstn && !abort_hit && vld_reg[DEPTH-1];

   assign ce_ab  = accept;
   assign ce_mid = rstn && in_job;
   assign ce_p   = tag_out_vld;
   assign opmode = !tag_out_vld ? 8'h00 : (first_tag_reg[DEPTH-1] ? 8'h01 : 8'h09);
   assign rst_p  = !rstn || abort_hit;
   assign busy   = rstn && in_job;
   assign done   = rstn && (state_reg == DONE);
   assign err    = rstn && err_reg;

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Directed cycle-by-cycle bench for dsp_mac_seq (PIPE_LAT=4, LEN_W=8).
module tb_dsp_mac_seq;

   logic       clk;
   logic       rstn;
   logic       start;
   logic [7:0] len;
   logic       abort;
   logic       smp_valid;
   logic       smp_ready;
   logic       ce_ab;
   logic       ce_mid;
   logic       ce_p;
   logic       rst_p;
   logic [7:0] opmode;
   logic       busy;
   logic       done;
   logic       err;

   int tests_run = 0;
   int tests_failed = 0;

   dsp_mac_seq #(.LEN_W(8), .PIPE_LAT(4)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .start     (start),
      .len       (len),
      .abort     (abort),
      .smp_valid (smp_valid),
      .smp_ready (smp_ready),
      .ce_ab     (ce_ab),
      .ce_mid    (ce_mid),
      .ce_p      (ce_p),
      .rst_p     (rst_p),
      .opmode    (opmode),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {smp_ready, ce_ab, ce_mid, ce_p, rst_p, opmode, busy, done, err}
   logic [15:0] obs;
   assign obs = {smp_ready, ce_ab, ce_mid, ce_p, rst_p, opmode, busy, done, err};

   function automatic logic [15:0] mk(input logic r, ab, mid, p, rp,
                                      input logic [7:0] op, input logic b, d, e);
      return {r, ab, mid, p, rp, op, b, d, e};
   endfunction

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive inputs, sample mid-cycle, advance past the edge.
   task automatic cyc(input string tag, input logic rn, input logic st, input logic [7:0] ln,
                      input logic ab, input logic v, input logic [15:0] exp);
      rstn = rn; start = st; len = ln; abort = ab; smp_valid = v;
      @(negedge clk);
      $display("[TB] %s rstn=%b start=%b len=%0d abort=%b valid=%b out=%h", tag, rn, st, ln, ab, v, obs);
      check(tag, obs, exp);
      @(posedge clk);
      #1;
   endtask

   logic [15:0] z, run, drn, p01, p09, rp, dn, er, rp_drn, run_p01;

   initial begin
      z       = mk(0,0,0,0,0,8'h00,0,0,0);
      run     = mk(1,1,1,0,0,8'h00,1,0,0);
      drn     = mk(0,0,1,0,0,8'h00,1,0,0);
      p01     = mk(0,0,1,1,0,8'h01,1,0,0);
      p09     = mk(0,0,1,1,0,8'h09,1,0,0);
      rp      = mk(0,0,0,0,1,8'h00,0,0,0);
      rp_drn  = mk(0,0,1,0,1,8'h00,1,0,0);
      dn      = mk(0,0,0,0,0,8'h00,0,1,0);
      er      = mk(0,0,0,0,0,8'h00,0,0,1);
      run_p01 = mk(1,1,1,1,0,8'h01,1,0,0);
      rstn = 1'b0; start = 1'b0; len = 8'd0; abort = 1'b0; smp_valid = 1'b0;

      cyc("reset",   0, 0, 0, 0, 1, rp);
      cyc("idle",    1, 0, 0, 0, 1, z);

      // len=3, valid held high
      cyc("t1c0", 1, 1, 3, 0, 1, z);
      cyc("t1c1", 1, 0, 0, 0, 1, run);
      cyc("t1c2", 1, 0, 0, 0, 1, run);
      cyc("t1c3", 1, 0, 0, 0, 1, run);
      cyc("t1c4", 1, 0, 0, 0, 1, p01);
      cyc("t1c5", 1, 0, 0, 0, 1, p09);
      cyc("t1c6", 1, 0, 0, 0, 1, p09);
      cyc("t1c7", 1, 0, 0, 0, 1, dn);
      cyc("t1c8", 1, 0, 0, 0, 1, z);

      // len=4 with bubbles on 2nd/3rd sample cycles, then back-to-back len=2 from DONE
      cyc("t2c0",  1, 1, 4, 0, 1, z);
      cyc("t2c1",  1, 0, 0, 0, 1, run);
      cyc("t2c2",  1, 0, 0, 0, 0, mk(1,0,1,0,0,8'h00,1,0,0));
      cyc("t2c3",  1, 0, 0, 0, 0, mk(1,0,1,0,0,8'h00,1,0,0));
      cyc("t2c4",  1, 0, 0, 0, 1, run_p01);
      cyc("t2c5",  1, 0, 0, 0, 1, run);
      cyc("t2c6",  1, 0, 0, 0, 1, run);
      cyc("t2c7",  1, 0, 0, 0, 1, p09);
      cyc("t2c8",  1, 0, 0, 0, 1, p09);
      cyc("t2c9",  1, 0, 0, 0, 1, p09);
      cyc("t5c0",  1, 1, 2, 0, 1, dn);
      cyc("t5c1",  1, 0, 0, 0, 1, run);
      cyc("t5c2",  1, 0, 0, 0, 1, run);
      cyc("t5c3",  1, 0, 0, 0, 1, drn);
      cyc("t5c4",  1, 0, 0, 0, 1, p01);
      cyc("t5c5",  1, 0, 0, 0, 1, p09);
      cyc("t5c6",  1, 0, 0, 0, 1, dn);
      cyc("t5c7",  1, 0, 0, 0, 1, z);

      // abort in DRAIN one cycle before done, then a fresh len=1 job
      cyc("t3c0",  1, 1, 3, 0, 1, z);
      cyc("t3c1",  1, 0, 0, 0, 1, run);
      cyc("t3c2",  1, 0, 0, 0, 1, run);
      cyc("t3c3",  1, 0, 0, 0, 1, run);
      cyc("t3c4",  1, 0, 0, 0, 1, p01);
      cyc("t3c5",  1, 0, 0, 0, 1, p09);
      cyc("t3c6",  1, 0, 0, 1, 1, rp_drn);
      cyc("t3c7",  1, 0, 0, 0, 1, z);
      cyc("t3c8",  1, 1, 1, 0, 1, z);
      cyc("t3c9",  1, 0, 0, 0, 1, run);
      cyc("t3c10", 1, 0, 0, 0, 1, drn);
      cyc("t3c11", 1, 0, 0, 0, 1, drn);
      cyc("t3c12", 1, 0, 0, 0, 1, p01);
      cyc("t3c13", 1, 0, 0, 0, 1, dn);
      cyc("t3c14", 1, 0, 0, 0, 1, z);

      // len=0 error, then start during RUN ignored
      cyc("t4c0",  1, 1, 0, 0, 0, z);
      cyc("t4c1",  1, 0, 0, 0, 0, er);
      cyc("t4c2",  1, 0, 0, 0, 0, z);
      cyc("t4d0",  1, 1, 2, 0, 1, z);
      cyc("t4d1",  1, 1, 5, 0, 1, run);
      cyc("t4d2",  1, 1, 5, 0, 1, run);
      cyc("t4d3",  1, 0, 0, 0, 1, drn);
      cyc("t4d4",  1, 0, 0, 0, 1, p01);
      cyc("t4d5",  1, 0, 0, 0, 1, p09);
      cyc("t4d6",  1, 0, 0, 0, 1, dn);
      cyc("t4d7",  1, 0, 0, 0, 1, z);

      // reset mid-RUN drops pending tags
      cyc("t6c0",  1, 1, 3, 0, 1, z);
      cyc("t6c1",  1, 0, 0, 0, 1, run);
      cyc("t6c2",  0, 0, 0, 0, 1, rp);
      cyc("t6c3",  1, 0, 0, 0, 0, z);
      cyc("t6c4",  1, 0, 0, 0, 0, z);
      cyc("t6c5",  1, 0, 0, 0, 0, z);
      cyc("t6c6",  1, 0, 0, 0, 0, z);
      cyc("t6c7",  1, 0, 0, 0, 0, z);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
